// File: rtl/inv_key_schedule.sv
// AES-128 reverse key schedule: walks a round-10 key back to the cipher key,
// presenting one round key per valid/ready handshake.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX_TBL[{a_i, 3'b000} +: 8];
endmodule

module inv_key_schedule #(
  parameter bit EMIT_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key_last,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [0:127] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

  state_t       state_q;
  logic [0:127] key_q;
  logic [3:0]   round_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot, sub;
  logic [7:0]   rc;
  logic [0:127] key_d;

  assign w0 = key_q[0:31];
  assign w1 = key_q[32:63];
  assign w2 = key_q[64:95];
  assign w3 = key_q[96:127];

  // Undo the xor chain first; P3 equals w[4r-1], the word fed to the g() function.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .a_i (rot[8*gi +: 8]),
        .y_o (sub[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    rc = 8'h00;
    case (round_q)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign p0    = w0 ^ sub ^ {rc, 24'h000000};
  assign key_d = {p0, p1, p2, p3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            key_q   <= key_last;
            round_q <= 4'd10;
            busy_q  <= 1'b1;
            if (EMIT_FIRST) begin
              valid_q <= 1'b1;
              state_q <= EMIT;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          key_q   <= key_d;
          round_q <= round_q - 4'd1;
          valid_q <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: begin
          // Stepping on the handshake edge keeps valid high: one key per cycle.
          if (rk_ready) begin
            if (round_q != 4'd0) begin
              key_q   <= key_d;
              round_q <= round_q - 4'd1;
            end else begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_valid = valid_q;
  assign rk       = key_q;
  assign rk_round = round_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 A.1 sequence, backpressure,
// EMIT_FIRST=0, start while busy, mid-run reset and an all-zero key.

module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_a = 1'b0, rdy_a = 1'b0;
  logic         start_b = 1'b0, rdy_b = 1'b0;
  logic [0:127] key_last = '0;

  logic         val_a, busy_a, done_a;
  logic [0:127] rk_a;
  logic [3:0]   rnd_a;
  logic         val_b, busy_b, done_b;
  logic [0:127] rk_b;
  logic [3:0]   rnd_b;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  logic [127:0] exp_keys [0:10];
  logic [7:0]   sbox_m   [0:255];

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  inv_key_schedule #(.EMIT_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .key_last(key_last),
    .rk_ready(rdy_a), .rk_valid(val_a), .rk(rk_a), .rk_round(rnd_a),
    .busy(busy_a), .done(done_a)
  );

  inv_key_schedule #(.EMIT_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key_last(key_last),
    .rk_ready(rdy_b), .rk_valid(val_b), .rk(rk_b), .rk_round(rnd_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Reference S-box built from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[i] = s;
    end
  endtask

  function automatic logic [127:0] model_prev(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t, s;
    logic [7:0]  rc;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    t = {w3 ^ w2};
    t = {t[23:0], t[31:24]};
    s = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    return {w0 ^ s ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  endfunction

  // Start dut_a with rk_ready held high and check all 11 keys back to back.
  task automatic run_a(input string tag);
    int d0;
    d0 = done_cnt_a;
    rdy_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tag, "_busy"}, busy_a, 1);
    for (int r = 10; r >= 0; r--) begin
      chk($sformatf("%s_valid_r%0d", tag, r), val_a, 1);
      chk($sformatf("%s_round_r%0d", tag, r), rnd_a, r);
      chk($sformatf("%s_rk_r%0d", tag, r), rk_a, exp_keys[r]);
      tick();
    end
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_valid_drop"}, val_a, 0);
    chk({tag, "_busy_drop"}, busy_a, 0);
    tick();
    chk({tag, "_done_pulse"}, done_a, 0);
    chk({tag, "_done_count"}, done_cnt_a - d0, 1);
    rdy_a = 1'b0;
  endtask

  initial begin
    int er, d0, n_keys;
    bit fin, hs, injected;
    logic [127:0] cur;

    build_sbox();
    exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_keys[10] = K10;

    // Asynchronous reset before the first clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_a", val_a, 0);
    chk("rst_rk_a", rk_a, 0);
    chk("rst_round_a", rnd_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_valid_b", val_b, 0);
    chk("rst_busy_b", busy_b, 0);
    tick(); tick();
    rst_n = 1'b1;
    rdy_a = 1'b1;
    tick();
    chk("idle_ready_no_effect", val_a, 0);

    $display("step: FIPS-197 A.1 continuous ready");
    key_last = K10;
    run_a("a1");

    $display("step: backpressure with start pulse while busy");
    rdy_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    er = 10; fin = 1'b0; injected = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      chk($sformatf("bp_valid_c%0d", cyc), val_a, 1);
      chk($sformatf("bp_round_c%0d", cyc), rnd_a, er);
      chk($sformatf("bp_rk_c%0d", cyc), rk_a, exp_keys[er]);
      if (er == 7 && !injected) begin
        start_a = 1'b1;
        key_last = 128'h11111111222222223333333344444444;
        injected = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      rdy_a = 1'($urandom_range(0, 1));
      hs = val_a && rdy_a;
      tick();
      if (hs) begin
        if (er == 0) fin = 1'b1;
        else er--;
      end
    end
    start_a = 1'b0;
    chk("bp_finished", fin, 1);
    chk("bp_done", done_a, 1);
    // This cycle is DONE: a start here must be dropped.
    key_last = K10; start_a = 1'b1;
    tick();
    start_a = 1'b0; rdy_a = 1'b0;
    chk("done_start_busy", busy_a, 0);
    chk("done_start_valid", val_a, 0);
    tick();
    chk("done_start_busy2", busy_a, 0);

    $display("step: EMIT_FIRST=0 instance");
    d0 = done_cnt_b;
    key_last = K10; rdy_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("ef0_calc_valid", val_b, 0);
    chk("ef0_calc_busy", busy_b, 1);
    tick();
    n_keys = 0;
    for (int r = 9; r >= 0; r--) begin
      chk($sformatf("ef0_valid_r%0d", r), val_b, 1);
      chk($sformatf("ef0_round_r%0d", r), rnd_b, r);
      chk($sformatf("ef0_rk_r%0d", r), rk_b, exp_keys[r]);
      if (val_b) n_keys++;
      tick();
    end
    chk("ef0_key_count", n_keys, 10);
    chk("ef0_done", done_b, 1);
    chk("ef0_valid_drop", val_b, 0);
    tick();
    chk("ef0_done_count", done_cnt_b - d0, 1);
    rdy_b = 1'b0;

    $display("step: reset after round 5 accepted");
    d0 = done_cnt_a;
    key_last = K10; rdy_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_round_before_rst", rnd_a, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", val_a, 0);
    chk("mid_rst_rk", rk_a, 0);
    chk("mid_rst_round", rnd_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    rdy_a = 1'b0;
    tick(); tick();
    chk("mid_rst_no_done", done_cnt_a - d0, 0);
    chk("mid_rst_idle_busy", busy_a, 0);
    run_a("rerun");

    $display("step: all-zero key against reference model");
    cur = '0;
    for (int r = 10; r >= 0; r--) begin
      exp_keys[r] = cur;
      if (r > 0) cur = model_prev(cur, r);
    end
    key_last = '0;
    run_a("zero");
    tick();
    chk("zero_done_quiet", done_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have parameter EMIT_FIRST, default 1, where 1 means the round-10 key is emitted first and 0 means emission starts at round 9.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin reverse expansion; sampled only in IDLE.
REQ-005 The block SHALL have port key_last, input, 128 bits [0:127]: AES-128 round-10 key, with bit 0 the MSB of byte 0, word order w40..w43; sampled on the accepted start.
REQ-006 The block SHALL have port rk_ready, input, 1 bit: consumer accepts rk this cycle.
REQ-007 The block SHALL have port rk_valid, output, 1 bit: rk and rk_round hold a valid round key.
REQ-008 The block SHALL have port rk, output, 128 bits [0:127]: current round key, using the same bit order as key_last.
REQ-009 The block SHALL have port rk_round, output, 4 bits: round index of rk, from 10 down to 0.
REQ-010 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the round-0 key is accepted.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, EMIT and DONE, encoded in registers.
REQ-013 In IDLE with start=1, the block SHALL load key_last into the key register and set rk_round=10, then go to EMIT if EMIT_FIRST=1 or to CALC if EMIT_FIRST=0.
REQ-014 CALC SHALL replace the key with the previous-round key, decrement rk_round, and go to EMIT in 1 cycle.
REQ-015 Previous-key computation, with current words W0..W3 for round r: P3=W3^W2, P2=W2^W1, P1=W1^W0, P0=W0^SubWord(RotWord(P3))^Rcon[r].
REQ-016 RotWord SHALL be a cyclic left rotation by one byte, SubWord SHALL apply the forward AES S-box to each of the 4 bytes (4 sbox instances), and Rcon[r] SHALL be {RC[r],24'h0}.
REQ-017 RC[r] for r=1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-018 In EMIT, rk_valid SHALL be 1, and rk and rk_round SHALL stay stable until a handshake occurs (rk_valid and rk_ready).
REQ-019 On a handshake in EMIT with rk_round>0, the key SHALL be updated per REQ-015 in the same edge and rk_round decremented; rk_valid SHALL remain 1, giving throughput of 1 key/cycle under continuous rk_ready.
REQ-020 On a handshake in EMIT with rk_round=0, the FSM SHALL go to DONE and rk_valid SHALL drop the next cycle.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, deassert busy, and return to IDLE.
REQ-022 start SHALL be ignored in CALC, EMIT and DONE; start high in the DONE cycle SHALL NOT be accepted, so a restart is possible no earlier than the IDLE cycle.
REQ-023 rk_ready while rk_valid=0 SHALL have no effect.
REQ-024 Latency from start to first rk_valid SHALL be 1 cycle (EMIT_FIRST=1) or 2 cycles (EMIT_FIRST=0).
REQ-025 Keys SHALL be emitted 11 times (rounds 10..0) for EMIT_FIRST=1 and 10 times (rounds 9..0) for EMIT_FIRST=0.
REQ-026 rk_round SHALL never wrap below 0, and no state SHALL index Rcon[0].

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, rk=0, rk_round=0, rk_valid=0, busy=0 and done=0.
REQ-028 rst_n asserted mid-operation SHALL abort the sequence immediately, with no done pulse; after release the block SHALL accept start normally.

Verification
REQ-029 Bench scenario, FIPS-197 A.1: key_last=d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1 -> rk_round 10..0 on consecutive cycles, round 9 = ac7766f319fadc2128d12941575c006e, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done 1 cycle after round 0.
REQ-030 Bench scenario, backpressure: same key, rk_ready toggled randomly -> identical key sequence, rk and rk_round stable while rk_valid=1 and rk_ready=0, no key skipped or repeated.
REQ-031 Bench scenario, EMIT_FIRST=0: same key -> first rk_valid 2 cycles after start with rk_round=9 and rk=ac7766f3..., 10 keys total.
REQ-032 Bench scenario, start while busy: pulse start with a different key_last during EMIT -> ignored, sequence unchanged; start in the DONE cycle ignored.
REQ-033 Bench scenario, reset mid-run: rst_n low after round 5 is accepted -> all outputs 0 asynchronously and no done; a new start yields a full correct sequence.
REQ-034 Bench scenario, all-zero key_last: compare every round key against a reference-model reverse expansion -> exact match, done asserted once.
